lc3_fetch_unit: RTL and testbench
=================================

// Module: lc3_fetch_unit
// PURPOSE
//  LC-3 instruction fetch sequencer; the consumer side of the PC register.
//  Reads the current PC, drives the PC-increment load request, fetches M[PC] over a
//  ready-handshaked memory port and delivers IR to decode with a valid/ready handshake.
//  Sits between the PC register, the memory port and the decode/control unit.
// PARAMETERS
//  ADDR_W       16   address width (PC / MAR)
//  DATA_W       16   instruction width (MDR / IR)
//  TIMEOUT_CYC  255  FETCH2 wait limit in cycles (used only with LC3_FETCH_TIMEOUT_EN)
// PORTS
//  clk           in   1       clock; all state updates on posedge
//  rst           in   1       synchronous, active-high reset
//  i_run         in   1       1 = fetch continuously; 0 = stop after the current delivery
//  i_pc          in   ADDR_W  current PC value from the PC register
//  i_redirect    in   1       branch/jump is loading PC this cycle; flush the fetch in flight
//  o_ld_pc       out  1       PC load enable request (one-cycle pulse)
//  o_pc_mux      out  2       PC source select; always 2'b00 (pc+1)
//  o_mem_addr    out  ADDR_W  memory address (MAR)
//  o_mem_en      out  1       memory read request
//  i_mem_rdata   in   DATA_W  memory read data
//  i_mem_ready   in   1       read data valid this cycle
//  o_ir          out  DATA_W  fetched instruction
//  o_ir_valid    out  1       o_ir valid for decode
//  i_ir_ready    in   1       decode accepts o_ir
//  o_fetch_cnt   out  16      completed deliveries; wraps 16'hFFFF -> 0
//  o_fetch_fault out  1       sticky memory timeout flag
// BEHAVIOUR
//  Reset: state=IDLE; MAR, MDR, IR, o_fetch_cnt = 0; o_ld_pc, o_mem_en, o_ir_valid, o_fetch_fault = 0.
//  FSM:
//   IDLE   -> FETCH1 when i_run=1.
//   FETCH1 -> MAR<=i_pc; o_ld_pc=1, o_pc_mux=00; -> FETCH2.
//   FETCH2 -> o_mem_en=1, o_mem_addr=MAR; on i_mem_ready: MDR<=i_mem_rdata, -> FETCH3; else stay.
//   FETCH3 -> IR<=MDR; -> DELIVER.
//   DELIVER-> o_ir_valid=1, o_ir stable; on i_ir_ready: cnt+1, -> FETCH1 if i_run else IDLE.
//  Latency: FETCH1 to o_ir_valid = 3 cycles with zero memory wait; +1 per FETCH2 wait cycle.
//  o_ld_pc pulses exactly once per fetch, in FETCH1 only; o_mem_en is high only in FETCH2.
//  i_redirect (any non-IDLE state) dominates:
//   - o_ld_pc and o_ir_valid forced 0 that cycle; no transfer is counted.
//   - Any MDR capture is discarded; next state is FETCH1, which samples the new PC.
//   - The memory port tolerates o_mem_en dropping without ready (abort is legal).
//  i_redirect in IDLE is ignored.
//  i_run=0 mid-fetch: the current fetch completes and is delivered, then IDLE.
//  Simultaneous i_mem_ready and i_redirect in FETCH2: redirect wins; data is dropped.
//  rst mid-operation: immediate return to reset values on the next edge, incl. o_fetch_fault.
// CONFIGURATION
//  LC3_FETCH_TIMEOUT_EN defined:
//   - Wait counter clears on entry to FETCH2 and counts FETCH2 cycles without i_mem_ready.
//   - At TIMEOUT_CYC: o_fetch_fault<=1 (sticky until rst); FSM -> IDLE and ignores i_run
//     while the fault is set.
//  Undefined: no counter; FETCH2 waits indefinitely; o_fetch_fault tied 0.
// STRUCTURE
//  Shared package lc3_defs: FSM state encodings (IDLE, FETCH1, FETCH2, FETCH3, DELIVER);
//   PC_MUX_INC=2'b00, PC_MUX_BUS=2'b01, PC_MUX_JMP=2'b10.
//  One sub-module: lc3_wdog_counter (clear/enable/terminal-count), instantiated only under
//   LC3_FETCH_TIMEOUT_EN.
// TESTING
//  1 Reset then i_run=1, i_pc=16'h3000, ready in the first FETCH2 cycle, rdata=16'h1234
//    -> one o_ld_pc pulse, o_mem_addr=3000, o_ir=1234 valid 3 cycles after FETCH1,
//    o_fetch_cnt=1.
//  2 Memory ready delayed 4 cycles -> o_mem_en held 5 cycles, o_mem_addr stable,
//    o_ir_valid at cycle 7.
//  3 i_ir_ready held low 10 cycles in DELIVER -> o_ir stable, no new o_ld_pc or o_mem_en.
//  4 i_redirect with i_mem_ready in FETCH2 (i_pc now 16'h4000) -> data dropped, cnt
//    unchanged, next fetch from 4000.
//  5 Preload o_fetch_cnt to 16'hFFFF, complete a fetch -> 0; i_run=0 during FETCH2 ->
//    delivery then IDLE.
//  6 LC3_FETCH_TIMEOUT_EN, TIMEOUT_CYC=8, ready never asserted -> fault=1 after 8 wait
//    cycles, IDLE, stays until rst; macro off -> waits forever, fault=0.

Source files
------------

// File: rtl/lc3_defs_pkg.sv
// Shared LC-3 fetch definitions: FSM state encodings, PC source selects, counter width.
package lc3_defs;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH1  = 3'd1,
        FETCH2  = 3'd2,
        FETCH3  = 3'd3,
        DELIVER = 3'd4
    } fetch_state_t;

    localparam logic [1:0] PC_MUX_INC = 2'b00;
    localparam logic [1:0] PC_MUX_BUS = 2'b01;
    localparam logic [1:0] PC_MUX_JMP = 2'b10;

    localparam int unsigned FETCH_CNT_W = 16;

    // True for the three PC source selects the PC register understands.
    function automatic logic pc_mux_legal(input logic [1:0] sel);
        return (sel == PC_MUX_INC) || (sel == PC_MUX_BUS) || (sel == PC_MUX_JMP);
    endfunction

endpackage

// File: rtl/lc3_wdog_counter.sv
// Wait-cycle watchdog: clears on i_clr, counts enabled cycles, flags the TERM-th one.
module lc3_wdog_counter
#(
    parameter int unsigned TERM = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc_c
);

    localparam int unsigned CNT_W = (TERM > 1) ? $clog2(TERM) : 1;

    logic [CNT_W-1:0] r_cnt;

    // Terminal count fires on the enabled cycle that would be the TERM-th.
    assign o_tc_c = i_en && (r_cnt == CNT_W'(TERM - 1));

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_tc_c) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/lc3_fetch_unit.sv
// LC-3 instruction fetch sequencer: PC -> MAR, M[MAR] -> MDR -> IR, IR handed to decode.
// Optional FETCH2 timeout with sticky fault is enabled by defining LC3_FETCH_TIMEOUT_EN.
module lc3_fetch_unit
    import lc3_defs::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_run,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic              i_redirect,
    output logic              o_ld_pc,
    output logic [1:0]        o_pc_mux,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_en,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_ready,
    output logic [DATA_W-1:0] o_ir,
    output logic              o_ir_valid,
    input  logic              i_ir_ready,
    output logic [15:0]       o_fetch_cnt,
    output logic              o_fetch_fault
);

    if (TIMEOUT_CYC == 0) begin : g_bad_timeout
        $error("lc3_fetch_unit: TIMEOUT_CYC must be at least 1");
    end

    fetch_state_t           r_state;
    logic [ADDR_W-1:0]      r_mar;
    logic [DATA_W-1:0]      r_mdr;
    logic [DATA_W-1:0]      r_ir;
    logic [FETCH_CNT_W-1:0] r_fetch_cnt;
    logic                   r_ld_pc;
    logic                   r_mem_en;
    logic                   r_ir_valid;

    logic w_flush;
    logic w_timeout;
    logic w_fault_block;

    assign w_flush = i_redirect && (r_state != IDLE);

`ifdef LC3_FETCH_TIMEOUT_EN
    logic w_wd_clr;
    logic w_wd_en;
    logic r_fault;

    assign w_wd_clr = (r_state == FETCH1);
    assign w_wd_en  = (r_state == FETCH2) && !i_mem_ready && !i_redirect;

    lc3_wdog_counter #(
        .TERM (TIMEOUT_CYC)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_wd_clr),
        .i_en   (w_wd_en),
        .o_tc_c (w_timeout)
    );

    // Sticky until reset; holds the FSM in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault <= 1'b0;
        end else if (w_timeout) begin
            r_fault <= 1'b1;
        end
    end

    assign w_fault_block = r_fault;
    assign o_fetch_fault = r_fault;
`else
    assign w_timeout     = 1'b0;
    assign w_fault_block = 1'b0;
    assign o_fetch_fault = 1'b0;
`endif

    // Single-process FSM; flags are set on entry to the state that owns them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mar       <= '0;
            r_mdr       <= '0;
            r_ir        <= '0;
            r_fetch_cnt <= '0;
            r_ld_pc     <= 1'b0;
            r_mem_en    <= 1'b0;
            r_ir_valid  <= 1'b0;
        end else if (w_flush) begin
            r_state    <= FETCH1;
            r_ld_pc    <= 1'b1;
            r_mem_en   <= 1'b0;
            r_ir_valid <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (i_run && !w_fault_block) begin
                        r_state <= FETCH1;
                        r_ld_pc <= 1'b1;
                    end
                end
                FETCH1: begin
                    r_mar    <= i_pc;
                    r_ld_pc  <= 1'b0;
                    r_mem_en <= 1'b1;
                    r_state  <= FETCH2;
                end
                FETCH2: begin
                    if (i_mem_ready) begin
                        r_mdr    <= i_mem_rdata;
                        r_mem_en <= 1'b0;
                        r_state  <= FETCH3;
                    end else if (w_timeout) begin
                        r_mem_en <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                FETCH3: begin
                    r_ir       <= r_mdr;
                    r_ir_valid <= 1'b1;
                    r_state    <= DELIVER;
                end
                DELIVER: begin
                    if (i_ir_ready) begin
                        r_fetch_cnt <= r_fetch_cnt + FETCH_CNT_W'(1);
                        r_ir_valid  <= 1'b0;
                        if (i_run) begin
                            r_state <= FETCH1;
                            r_ld_pc <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_ld_pc    <= 1'b0;
                    r_mem_en   <= 1'b0;
                    r_ir_valid <= 1'b0;
                end
            endcase
        end
    end

    // A redirect owns the PC this cycle, so the increment request and the delivery are masked.
    assign o_ld_pc     = r_ld_pc && !w_flush;
    assign o_ir_valid  = r_ir_valid && !w_flush;
    assign o_pc_mux    = PC_MUX_INC;
    assign o_mem_addr  = r_mar;
    assign o_mem_en    = r_mem_en;
    assign o_ir        = r_ir;
    assign o_fetch_cnt = r_fetch_cnt;

endmodule

// File: tb/tb_lc3_fetch_unit.sv
// Directed bench for lc3_fetch_unit: per-cycle vector table plus wrap and timeout sequences.
module tb_lc3_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_run;
    logic [15:0] i_pc;
    logic        i_redirect;
    logic        o_ld_pc;
    logic [1:0]  o_pc_mux;
    logic [15:0] o_mem_addr;
    logic        o_mem_en;
    logic [15:0] i_mem_rdata;
    logic        i_mem_ready;
    logic [15:0] o_ir;
    logic        o_ir_valid;
    logic        i_ir_ready;
    logic [15:0] o_fetch_cnt;
    logic        o_fetch_fault;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

`ifdef LC3_FETCH_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 8;
`else
    localparam int unsigned TB_TIMEOUT = 255;
`endif

    lc3_fetch_unit #(
        .ADDR_W      (16),
        .DATA_W      (16),
        .TIMEOUT_CYC (TB_TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_run         (i_run),
        .i_pc          (i_pc),
        .i_redirect    (i_redirect),
        .o_ld_pc       (o_ld_pc),
        .o_pc_mux      (o_pc_mux),
        .o_mem_addr    (o_mem_addr),
        .o_mem_en      (o_mem_en),
        .i_mem_rdata   (i_mem_rdata),
        .i_mem_ready   (i_mem_ready),
        .o_ir          (o_ir),
        .o_ir_valid    (o_ir_valid),
        .i_ir_ready    (i_ir_ready),
        .o_fetch_cnt   (o_fetch_cnt),
        .o_fetch_fault (o_fetch_fault)
    );

    typedef struct {
        logic        run;
        logic        redir;
        logic        mrdy;
        logic        irdy;
        logic [15:0] pc;
        logic [15:0] rdata;
        logic        e_ld;
        logic        e_men;
        logic        e_iv;
        logic [15:0] e_addr;
        logic [15:0] e_ir;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic run, input logic redir, input logic mrdy,
                               input logic irdy, input logic [15:0] pc,
                               input logic [15:0] rdata, input logic e_ld,
                               input logic e_men, input logic e_iv,
                               input logic [15:0] e_addr, input logic [15:0] e_ir,
                               input logic [15:0] e_cnt);
        vec_t r;
        r.run = run; r.redir = redir; r.mrdy = mrdy; r.irdy = irdy;
        r.pc = pc; r.rdata = rdata;
        r.e_ld = e_ld; r.e_men = e_men; r.e_iv = e_iv;
        r.e_addr = e_addr; r.e_ir = e_ir; r.e_cnt = e_cnt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Move to just after the next rising edge, where inputs are changed.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] snap();
        return 64'({o_ld_pc, o_mem_en, o_ir_valid, o_fetch_fault, o_mem_addr, o_ir, o_fetch_cnt});
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench timeout");
    end

    initial begin
        int men_cycles;

        // Rows describe one clock cycle: inputs held that cycle, outputs seen that cycle.
        vecs.push_back(v(1,0,0,1,16'h3000,16'h0000, 0,0,0,16'h0000,16'h0000,16'd0));
        vecs.push_back(v(1,0,0,1,16'h3000,16'h0000, 1,0,0,16'h0000,16'h0000,16'd0));
        vecs.push_back(v(1,0,1,1,16'h3000,16'h1234, 0,1,0,16'h3000,16'h0000,16'd0));
        vecs.push_back(v(1,0,0,1,16'h3001,16'h0000, 0,0,0,16'h3000,16'h0000,16'd0));
        vecs.push_back(v(1,0,0,1,16'h3001,16'h0000, 0,0,1,16'h3000,16'h1234,16'd0));
        vecs.push_back(v(1,0,0,1,16'h3001,16'h0000, 1,0,0,16'h3000,16'h1234,16'd1));
        for (int k = 0; k < 4; k++)
            vecs.push_back(v(1,0,0,1,16'h3001,16'h0000, 0,1,0,16'h3001,16'h1234,16'd1));
        vecs.push_back(v(1,0,1,1,16'h3001,16'h5678, 0,1,0,16'h3001,16'h1234,16'd1));
        vecs.push_back(v(1,0,0,1,16'h3002,16'h0000, 0,0,0,16'h3001,16'h1234,16'd1));
        for (int k = 0; k < 10; k++)
            vecs.push_back(v(1,0,0,0,16'h3002,16'h0000, 0,0,1,16'h3001,16'h5678,16'd1));
        vecs.push_back(v(1,0,0,1,16'h3002,16'h0000, 0,0,1,16'h3001,16'h5678,16'd1));
        vecs.push_back(v(1,0,0,1,16'h3002,16'h0000, 1,0,0,16'h3001,16'h5678,16'd2));
        vecs.push_back(v(1,1,1,1,16'h4000,16'hDEAD, 0,1,0,16'h3002,16'h5678,16'd2));
        vecs.push_back(v(1,0,0,1,16'h4000,16'h0000, 1,0,0,16'h3002,16'h5678,16'd2));
        vecs.push_back(v(1,0,1,1,16'h4000,16'hABCD, 0,1,0,16'h4000,16'h5678,16'd2));
        vecs.push_back(v(0,0,0,1,16'h4000,16'h0000, 0,0,0,16'h4000,16'h5678,16'd2));
        vecs.push_back(v(0,0,0,1,16'h4000,16'h0000, 0,0,1,16'h4000,16'hABCD,16'd2));
        vecs.push_back(v(0,0,0,1,16'h4000,16'h0000, 0,0,0,16'h4000,16'hABCD,16'd3));
        vecs.push_back(v(0,1,0,1,16'h4000,16'h0000, 0,0,0,16'h4000,16'hABCD,16'd3));
        vecs.push_back(v(1,0,0,1,16'h5000,16'h0000, 0,0,0,16'h4000,16'hABCD,16'd3));
        vecs.push_back(v(1,0,0,1,16'h5000,16'h0000, 1,0,0,16'h4000,16'hABCD,16'd3));
        vecs.push_back(v(1,0,1,1,16'h5000,16'h1111, 0,1,0,16'h5000,16'hABCD,16'd3));
        vecs.push_back(v(1,0,0,1,16'h5000,16'h0000, 0,0,0,16'h5000,16'hABCD,16'd3));
        vecs.push_back(v(1,1,0,1,16'h6000,16'h0000, 0,0,0,16'h5000,16'h1111,16'd3));
        vecs.push_back(v(1,0,0,1,16'h6000,16'h0000, 1,0,0,16'h5000,16'h1111,16'd3));
        vecs.push_back(v(0,0,1,1,16'h6000,16'h2222, 0,1,0,16'h6000,16'h1111,16'd3));
        vecs.push_back(v(0,0,0,1,16'h6000,16'h0000, 0,0,0,16'h6000,16'h1111,16'd3));
        vecs.push_back(v(0,0,0,1,16'h6000,16'h0000, 0,0,1,16'h6000,16'h2222,16'd3));
        vecs.push_back(v(1,0,0,1,16'h7000,16'h0000, 0,0,0,16'h6000,16'h2222,16'd4));
        vecs.push_back(v(1,1,0,1,16'h7000,16'h0000, 0,0,0,16'h6000,16'h2222,16'd4));
        vecs.push_back(v(1,0,0,1,16'h7000,16'h0000, 1,0,0,16'h6000,16'h2222,16'd4));
        vecs.push_back(v(0,0,0,1,16'h7000,16'h0000, 0,1,0,16'h7000,16'h2222,16'd4));
        vecs.push_back(v(0,0,1,1,16'h7000,16'h3333, 0,1,0,16'h7000,16'h2222,16'd4));
        vecs.push_back(v(0,0,0,1,16'h7000,16'h0000, 0,0,0,16'h7000,16'h2222,16'd4));
        vecs.push_back(v(0,0,0,1,16'h7000,16'h0000, 0,0,1,16'h7000,16'h3333,16'd4));
        vecs.push_back(v(0,0,0,1,16'h7000,16'h0000, 0,0,0,16'h7000,16'h3333,16'd5));

        rst = 1'b1; i_run = 1'b0; i_pc = 16'h0; i_redirect = 1'b0;
        i_mem_rdata = 16'h0; i_mem_ready = 1'b0; i_ir_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_state", snap(), 64'h0);
        chk("pc_mux_inc", 64'(o_pc_mux), 64'h0);
        tick();

        foreach (vecs[i]) begin
            i_run = vecs[i].run; i_redirect = vecs[i].redir; i_mem_ready = vecs[i].mrdy;
            i_ir_ready = vecs[i].irdy; i_pc = vecs[i].pc; i_mem_rdata = vecs[i].rdata;
            @(negedge clk);
            chk($sformatf("vec%0d", i), snap(),
                64'({vecs[i].e_ld, vecs[i].e_men, vecs[i].e_iv, 1'b0,
                     vecs[i].e_addr, vecs[i].e_ir, vecs[i].e_cnt}));
            tick();
        end

        // Delivery counter wrap from 16'hFFFF, with i_run dropped during FETCH2.
        force dut.r_fetch_cnt = 16'hFFFF;
        #1;
        release dut.r_fetch_cnt;
        i_run = 1'b1; i_redirect = 1'b0; i_pc = 16'h8000;
        i_mem_ready = 1'b1; i_mem_rdata = 16'h4444; i_ir_ready = 1'b1;
        tick();
        tick();
        i_run = 1'b0;
        @(negedge clk);
        chk("wrap_fetch2_mem_en", 64'({o_mem_en, o_mem_addr}), 64'({1'b1, 16'h8000}));
        tick();
        tick();
        @(negedge clk);
        chk("wrap_deliver", 64'({o_ir_valid, o_ir, o_fetch_cnt}), 64'({1'b1, 16'h4444, 16'hFFFF}));
        tick();
        @(negedge clk);
        chk("wrap_cnt_zero", 64'(o_fetch_cnt), 64'h0);
        repeat (3) tick();
        @(negedge clk);
        chk("wrap_then_idle", 64'({o_ld_pc, o_mem_en, o_ir_valid}), 64'h0);

        // Memory never ready: timeout build faults and parks, default build keeps waiting.
        rst = 1'b1;
        tick();
        rst = 1'b0; i_run = 1'b1; i_pc = 16'h9000; i_mem_ready = 1'b0;
        tick();
        tick();
        men_cycles = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (o_mem_en) men_cycles++;
            tick();
        end
        chk("wait_mem_en_cycles", 64'(men_cycles), 64'd8);
`ifdef LC3_FETCH_TIMEOUT_EN
        @(negedge clk);
        chk("timeout_fault", 64'({o_fetch_fault, o_mem_en, o_ld_pc}), 64'({1'b1, 1'b0, 1'b0}));
        men_cycles = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            @(negedge clk);
            if (o_ld_pc || o_mem_en) men_cycles++;
        end
        chk("fault_blocks_run", 64'(men_cycles), 64'd0);
        chk("fault_sticky", 64'(o_fetch_fault), 64'd1);
`else
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (o_mem_en) men_cycles++;
            tick();
        end
        @(negedge clk);
        chk("wait_forever", 64'({o_fetch_fault, o_mem_en, o_mem_addr, 16'(men_cycles)}),
            64'({1'b0, 1'b1, 16'h9000, 16'd308}));
`endif
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; i_run = 1'b0;
        @(negedge clk);
        chk("reset_mid_op", snap(), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
